axis_leaf_feeder: RTL and testbench

Parametrised front end for the merger tree. It terminates NUM_CH AXI-Stream input channels, unpacks each wide beat into C_SORTER_BIT_WIDTH records, and buffers the records in per-channel first-word-fall-through FIFOs that feed the tree leaves. Compared with the fixed 8-leaf front end, it adds tkeep-aware partial beats, optional end-of-stream terminator injection, per-channel record counters and done flags.

---
 rtl/axis_leaf_feeder.sv | 160 ++++++++++++++++
 tb/tb_axis_leaf_feeder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_leaf_feeder.sv
// Merger-tree front end: NUM_CH AXI-Stream inputs unpacked into RW-bit records,
// buffered in per-channel FWFT FIFOs that feed the tree leaves.
module axis_leaf_feeder #(
  parameter int NUM_CH             = 8,
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_SORTER_BIT_WIDTH = 32,
  parameter int FIFO_DEPTH         = 16,
  parameter bit TERM_EN            = 1'b1,
  parameter int TERM_VALUE         = -1,
  parameter int COUNT_WIDTH        = 32
) (
  input  logic                                   s_axis_aclk,
  input  logic                                   s_axis_areset,
  input  logic [NUM_CH-1:0]                      s_axis_tvalid,
  output logic [NUM_CH-1:0]                      s_axis_tready,
  input  logic [NUM_CH*C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [NUM_CH*C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [NUM_CH-1:0]                      s_axis_tlast,
  output logic [NUM_CH*C_SORTER_BIT_WIDTH-1:0]   leaf_data,
  output logic [NUM_CH-1:0]                      leaf_empty,
  input  logic [NUM_CH-1:0]                      leaf_deq,
  input  logic                                   stat_clr,
  output logic [NUM_CH*COUNT_WIDTH-1:0]          rec_count,
  output logic [NUM_CH-1:0]                      done
);
  localparam int DW   = C_AXIS_TDATA_WIDTH;
  localparam int RW   = C_SORTER_BIT_WIDTH;
  localparam int KW   = RW / 8;
  localparam int NREC = DW / RW;
  localparam int IW   = (NREC > 1) ? $clog2(NREC) : 1;
  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  // A signed int cast to RW bits truncates or sign-extends as needed.
  localparam logic [RW-1:0] TERM_REC = RW'(TERM_VALUE);

  typedef enum logic [1:0] {S_IDLE, S_UNPACK, S_TERM} state_t;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    state_t             state_q, state_d;
    logic [DW-1:0]      data_q, data_d;
    logic [NREC-1:0]    rem_q, rem_d, rem_rest, beat_vld;
    logic               last_q, last_d;
    logic               run_q;
    logic [IW-1:0]      idx;
    logic [RW-1:0]      mem [FIFO_DEPTH];
    logic [RW-1:0]      push_rec;
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [AW:0]        fcnt_q;
    logic [COUNT_WIDTH-1:0] rcnt_q;
    logic               done_q;
    logic               full, push, push_data, pop, set_done, accept;

    for (genvar gk = 0; gk < NREC; gk++) begin : g_vld
      assign beat_vld[gk] = &s_axis_tkeep[gi*(DW/8) + gk*KW +: KW];
    end

    // rem_q holds the not-yet-pushed valid records; the lowest set bit is next.
    assign rem_rest = rem_q & (rem_q - NREC'(1));

    always_comb begin
      idx = '0;
      for (int k = NREC - 1; k >= 0; k--) begin
        if (rem_q[k]) idx = IW'(k);
      end
    end

    assign full   = (fcnt_q == (AW+1)'(FIFO_DEPTH));
    assign pop    = leaf_deq[gi] && (fcnt_q != '0);
    assign accept = s_axis_tvalid[gi] && s_axis_tready[gi];

    always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      rem_d     = rem_q;
      last_d    = last_q;
      push      = 1'b0;
      push_data = 1'b0;
      set_done  = 1'b0;
      push_rec  = data_q[idx*RW +: RW];
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            data_d = s_axis_tdata[gi*DW +: DW];
            rem_d  = beat_vld;
            last_d = s_axis_tlast[gi];
            if (beat_vld != '0)                    state_d = S_UNPACK;
            else if (s_axis_tlast[gi] && TERM_EN)  state_d = S_TERM;
            else                                   set_done = s_axis_tlast[gi];
          end
        end
        S_UNPACK: begin
          if (!full) begin
            push      = 1'b1;
            push_data = 1'b1;
            rem_d     = rem_rest;
            if (rem_rest == '0) begin
              if (last_q && TERM_EN) begin
                state_d = S_TERM;
              end else begin
                state_d  = S_IDLE;
                set_done = last_q;
              end
            end
          end
        end
        S_TERM: begin
          push_rec = TERM_REC;
          if (!full) begin
            push     = 1'b1;
            set_done = 1'b1;
            state_d  = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_areset) begin
      if (!s_axis_areset) begin
        state_q  <= S_IDLE;
        data_q   <= '0;
        rem_q    <= '0;
        last_q   <= 1'b0;
        run_q    <= 1'b0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        fcnt_q   <= '0;
        rcnt_q   <= '0;
        done_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        data_q  <= data_d;
        rem_q   <= rem_d;
        last_q  <= last_d;
        run_q   <= 1'b1;
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        if (push && !pop)      fcnt_q <= fcnt_q + 1'b1;
        else if (pop && !push) fcnt_q <= fcnt_q - 1'b1;
        if (stat_clr) begin
          rcnt_q <= '0;
          done_q <= 1'b0;
        end else begin
          if (push_data && !(&rcnt_q)) rcnt_q <= rcnt_q + 1'b1;
          if (set_done)                done_q <= 1'b1;
        end
      end
    end

    always_ff @(posedge s_axis_aclk) begin
      if (push) mem[wr_ptr_q] <= push_rec;
    end

    assign s_axis_tready[gi]                       = run_q && (state_q == S_IDLE);
    assign leaf_data[gi*RW +: RW]                  = mem[rd_ptr_q];
    assign leaf_empty[gi]                          = (fcnt_q == '0);
    assign rec_count[gi*COUNT_WIDTH +: COUNT_WIDTH] = rcnt_q;
    assign done[gi]                                = done_q;
  end

endmodule

// File: tb/tb_axis_leaf_feeder.sv
// Randomised bench for axis_leaf_feeder with a per-channel record-queue reference model.
`timescale 1ns/1ps
module tb_axis_leaf_feeder;
  localparam int NC = 8, DW = 512, RW = 32, KB = DW/8, NREC = DW/RW, CW = 32, QD = 1024;

  logic clk = 1'b0;
  logic rst_n;
  logic [NC-1:0]    tvalid, tready, tlast, leaf_empty, leaf_deq, done;
  logic [NC*DW-1:0] tdata;
  logic [NC*KB-1:0] tkeep;
  logic [NC*RW-1:0] leaf_data;
  logic [NC*CW-1:0] rec_count;
  logic             stat_clr;
  logic [NC-1:0]    nt_tready, nt_empty, nt_done;
  logic [NC*RW-1:0] nt_data;
  logic [NC*CW-1:0] nt_count;

  int n_tests = 0, n_fail = 0;
  logic [RW-1:0] mq [NC][QD];
  int  hd [NC], tl [NC], exp_cnt [NC];
  logic exp_done [NC];
  logic [DW-1:0] bd;

  always #5 clk = ~clk;

  axis_leaf_feeder dut (
    .s_axis_aclk(clk), .s_axis_areset(rst_n), .s_axis_tvalid(tvalid), .s_axis_tready(tready),
    .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tlast(tlast), .leaf_data(leaf_data),
    .leaf_empty(leaf_empty), .leaf_deq(leaf_deq), .stat_clr(stat_clr), .rec_count(rec_count),
    .done(done));

  axis_leaf_feeder #(.TERM_EN(1'b0)) dut_nt (
    .s_axis_aclk(clk), .s_axis_areset(rst_n), .s_axis_tvalid(tvalid), .s_axis_tready(nt_tready),
    .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tlast(tlast), .leaf_data(nt_data),
    .leaf_empty(nt_empty), .leaf_deq(leaf_deq), .stat_clr(stat_clr), .rec_count(nt_count),
    .done(nt_done));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: every fully-kept record in order, then a terminator if last.
  task automatic model_accept(input int c);
    logic [DW-1:0] d;
    logic [KB-1:0] k;
    d = tdata[c*DW +: DW];
    k = tkeep[c*KB +: KB];
    for (int r = 0; r < NREC; r++) begin
      if (k[r*4 +: 4] == 4'hF) begin
        mq[c][tl[c] % QD] = d[r*RW +: RW];
        tl[c]++;
        exp_cnt[c]++;
      end
    end
    if (tlast[c]) begin
      mq[c][tl[c] % QD] = 32'hFFFF_FFFF;
      tl[c]++;
      exp_done[c] = 1'b1;
    end
    $display("[TB] ch%0d beat keep=%h last=%0d queued=%0d", c, k, tlast[c], tl[c] - hd[c]);
  endtask

  task automatic model_clear_stats();
    for (int c = 0; c < NC; c++) begin
      exp_cnt[c]  = 0;
      exp_done[c] = 1'b0;
    end
  endtask

  // One clock: check popped heads against the model, then account for accepted beats.
  task automatic step(input logic [NC-1:0] deq);
    logic [NC-1:0] acc;
    leaf_deq = deq;
    acc = tvalid & tready;
    for (int c = 0; c < NC; c++) begin
      if (deq[c] && !leaf_empty[c]) begin
        if (hd[c] == tl[c]) check($sformatf("ch%0d_pop_beyond_model", c), leaf_empty[c], 1'b1);
        else begin
          check($sformatf("ch%0d_data", c), leaf_data[c*RW +: RW], mq[c][hd[c] % QD]);
          hd[c]++;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < NC; c++) if (acc[c]) model_accept(c);
    tvalid = tvalid & ~acc;
  endtask

  task automatic send(input int c, input logic [DW-1:0] d, input logic [KB-1:0] k, input logic l);
    tdata[c*DW +: DW] = d;
    tkeep[c*KB +: KB] = k;
    tlast[c] = l;
    tvalid[c] = 1'b1;
  endtask

  task automatic wait_sent(input bit rnd);
    for (int i = 0; i < 400 && tvalid != '0; i++) step(rnd ? NC'($urandom) : '0);
    check("accept_within_budget", tvalid, '0);
  endtask

  function automatic bit model_empty();
    for (int c = 0; c < NC; c++) if (hd[c] != tl[c]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(input bit rnd);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      if (tvalid == '0 && tready == '1 && leaf_empty == '1 && model_empty()) ok = 1'b1;
      else step(rnd ? NC'($urandom) : '1);
    end
    check("drain_complete", ok, 1'b1);
  endtask

  task automatic check_stats();
    for (int c = 0; c < NC; c++) begin
      check($sformatf("ch%0d_rec_count", c), rec_count[c*CW +: CW], CW'(exp_cnt[c]));
      check($sformatf("ch%0d_done", c), done[c], exp_done[c]);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int r = 0; r < NREC; r++) d[r*RW +: RW] = $urandom;
    return d;
  endfunction

  function automatic logic [KB-1:0] rand_keep();
    logic [KB-1:0] k;
    for (int r = 0; r < NREC; r++) begin
      case ($urandom_range(0, 3))
        0:       k[r*4 +: 4] = 4'h0;
        3:       k[r*4 +: 4] = 4'($urandom);
        default: k[r*4 +: 4] = 4'hF;
      endcase
    end
    return k;
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; tvalid = '0; tlast = '0; tdata = '0; tkeep = '0; leaf_deq = '0; stat_clr = 1'b0;
    for (int c = 0; c < NC; c++) begin hd[c] = 0; tl[c] = 0; end
    model_clear_stats();
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_tready", tready, '0);
    check("rst_leaf_empty", leaf_empty, 8'hFF);
    check("rst_done", done, '0);
    check_stats();
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("tready_after_release", tready, 8'hFF);

    // Basic ch0 beat, records 0x10..0x1F, latency to first record
    for (int r = 0; r < NREC; r++) bd[r*RW +: RW] = 32'h10 + r;
    send(0, bd, '1, 1'b0);
    step('0);
    check("basic_accepted", tvalid[0], 1'b0);
    check("basic_empty_t1", leaf_empty[0], 1'b1);
    step('0);
    check("basic_empty_t2", leaf_empty[0], 1'b0);
    check("basic_head", leaf_data[RW-1:0], 32'h10);
    drain(1'b0);
    check("basic_count16", rec_count[CW-1:0], 16);
    check_stats();

    // Backpressure on ch1: two full beats, no dequeue, then pops while full
    send(1, rand_data(), '1, 1'b0);
    wait_sent(1'b0);
    send(1, rand_data(), '1, 1'b0);
    wait_sent(1'b0);
    repeat (20) step('0);
    check("bp_stalled_tready", tready[1], 1'b0);
    check("bp_not_empty", leaf_empty[1], 1'b0);
    repeat (20) step(8'h02);
    drain(1'b0);
    check_stats();

    // Partial keep with last on ch2: records 0 and 2 kept, then terminator
    send(2, rand_data(), 64'h0000_0000_0000_0F0F, 1'b1);
    wait_sent(1'b0);
    drain(1'b0);
    check("partial_count2", rec_count[2*CW +: CW], 2);
    check("partial_done", done[2], 1'b1);
    check_stats();

    // Empty keep with last on ch3, with and without terminator injection
    send(3, rand_data(), '0, 1'b1);
    step('0);
    check("emptykeep_done_before_term", done[3], 1'b0);
    step('0);
    check("emptykeep_done_after_term", done[3], 1'b1);
    check("emptykeep_term_visible", leaf_empty[3], 1'b0);
    check("noterm_done", nt_done[3], 1'b1);
    check("noterm_nothing_pushed", nt_empty[3], 1'b1);
    check("noterm_count0", nt_count[3*CW +: CW], 0);
    drain(1'b0);
    check("emptykeep_count0", rec_count[3*CW +: CW], 0);
    check_stats();

    // Clear, then all channels concurrently with random dequeue
    stat_clr = 1'b1;
    step('0);
    stat_clr = 1'b0;
    model_clear_stats();
    check_stats();
    for (int c = 0; c < NC; c++) send(c, rand_data(), '1, 1'b0);
    wait_sent(1'b1);
    drain(1'b1);
    check_stats();
    repeat (4) begin
      for (int c = 0; c < NC; c++) send(c, rand_data(), rand_keep(), ($urandom_range(0, 3) == 0));
      wait_sent(1'b1);
    end
    drain(1'b1);
    check_stats();

    // stat_clr coinciding with a data push: clear wins
    send(0, rand_data(), 64'h0000_0000_0000_000F, 1'b0);
    step('0);
    stat_clr = 1'b1;
    step('0);
    stat_clr = 1'b0;
    model_clear_stats();
    check("clr_wins_count", rec_count[CW-1:0], 0);
    check("clr_done_all", done, '0);
    drain(1'b0);
    check_stats();

    // Reset while ch0 is unpacking record 5
    send(0, rand_data(), '1, 1'b0);
    step('0);
    repeat (5) step('0);
    rst_n = 1'b0;
    #1;
    check("midreset_empty", leaf_empty[0], 1'b1);
    check("midreset_count", rec_count[CW-1:0], 0);
    check("midreset_tready", tready, '0);
    for (int c = 0; c < NC; c++) begin hd[c] = 0; tl[c] = 0; end
    model_clear_stats();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int r = 0; r < NREC; r++) bd[r*RW +: RW] = 32'hA000 + r;
    send(0, bd, '1, 1'b0);
    wait_sent(1'b0);
    step('0);
    check("postreset_first_record", leaf_data[RW-1:0], 32'hA000);
    drain(1'b0);
    check_stats();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
